fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter between the VGA scan-out path and the pixel writers. It shares one synchronous single-port RGB RAM between three users: the display read port (absolute priority), a built-in clear engine that fills the buffer with one colour, and a req/ack pixel writer. It sits between `vga_controller` (its `pixel_address` drives `disp_addr`) and the frame-buffer RAM.

---
 rtl/fb_pkg.sv | 8 +
 rtl/fb_clear_counter.sv | 18 +
 rtl/fb_arbiter.sv | 78 +++++++
 tb/tb_fb_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and default sizes for the frame-buffer arbiter.
package fb_pkg;
  localparam int CW = 3;
  localparam int DEF_AW = 16;
  localparam int DEF_DEPTH = 19200;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {G_NONE, G_DISP, G_CLR, G_WR} grant_t;
endpackage

// File: rtl/fb_clear_counter.sv
// fb_clear_counter: clear-engine address counter with terminal-count flag.
module fb_clear_counter #(
  parameter int AW = 16,
  parameter int DEPTH = 19200
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          tc
);
  assign tc = addr == AW'(DEPTH - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) addr <= '0;
    else if (load || (en && tc)) addr <= '0;
    else if (en) addr <= addr + 1'b1;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter (display > clear engine > pixel writer).
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [CW-1:0] disp_rgb,
  output logic          disp_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_rgb,
  output logic          wr_ack,
  input  logic          clr_start,
  input  logic [CW-1:0] clr_rgb,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [CW-1:0] mem_wdata,
  input  logic [CW-1:0] mem_rdata
);
  state_t state, state_nxt;
  grant_t grant;
  logic [CW-1:0] clr_rgb_q;
  logic [AW-1:0] clr_addr;
  logic clr_tc, clr_load, disp_ok, wr_ok, rd_v, rd_oor;
  assign disp_ok = disp_addr < AW'(DEPTH);
  assign wr_ok = wr_addr < AW'(DEPTH);
  assign clr_load = state == IDLE && clr_start;
  always_comb begin
    state_nxt = state;
    grant = G_NONE;
    if (disp_req) grant = G_DISP;
    else if (state == CLEAR) grant = G_CLR;
    else if (wr_req) grant = G_WR;
    if (clr_load) state_nxt = CLEAR;
    else if (grant == G_CLR && clr_tc) state_nxt = IDLE;
  end
  assign wr_ack = grant == G_WR;
  assign clr_busy = state == CLEAR;
  assign mem_we = grant == G_CLR || (grant == G_WR && wr_ok);
  assign mem_addr = grant == G_DISP && disp_ok ? disp_addr :
                    grant == G_CLR ? clr_addr :
                    grant == G_WR && wr_ok ? wr_addr : '0;
  assign mem_wdata = grant == G_CLR ? clr_rgb_q : grant == G_WR && wr_ok ? wr_rgb : '0;
  fb_clear_counter #(.AW(AW), .DEPTH(DEPTH)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load(clr_load),
    .en(grant == G_CLR),
    .addr(clr_addr),
    .tc(clr_tc)
  );
  // Stage 1 tracks the read in flight; stage 2 registers the RAM data.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      clr_rgb_q <= '0;
      clr_done <= 1'b0;
      rd_v <= 1'b0;
      rd_oor <= 1'b0;
      disp_valid <= 1'b0;
      disp_rgb <= '0;
    end else begin
      state <= state_nxt;
      if (clr_load) clr_rgb_q <= clr_rgb;
      clr_done <= grant == G_CLR && clr_tc;
      rd_v <= disp_req;
      rd_oor <= !disp_ok;
      disp_valid <= rd_v;
      disp_rgb <= rd_v && !rd_oor ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized scoreboard bench for fb_arbiter with a frame-buffer reference model.
module tb_fb_arbiter;
  import fb_pkg::*;
  localparam int AW = 16;
  localparam int DEPTH = 19200;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic disp_req = 1'b0, wr_req = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] disp_addr = '0, wr_addr = '0;
  logic [CW-1:0] wr_rgb = '0, clr_rgb = '0;
  logic [CW-1:0] disp_rgb, mem_wdata, mem_rdata;
  logic disp_valid, wr_ack, clr_busy, clr_done, mem_we;
  logic [AW-1:0] mem_addr;
  fb_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rgb(disp_rgb), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_rgb(wr_rgb), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_rgb(clr_rgb), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #20 clock = ~clock;
  // Frame-buffer RAM, preloaded with addr[2:0] on the first edge.
  logic [CW-1:0] ram [DEPTH];
  bit loaded = 1'b0;
  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 3'(i);
      loaded <= 1'b1;
    end else if (mem_we && mem_addr < DEPTH) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_addr < DEPTH ? ram[mem_addr] : 3'b000;
  end
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      if (fails <= 40) $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask
  typedef struct {logic [CW-1:0] rgb; int cyc;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  always @(negedge clock)
    if (reset && disp_valid) begin
      if (sbq.size() == 0) chk("disp_unexpected", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("disp_rgb", disp_rgb, mon_e.rgb);
        chk("disp_latency", cyc - mon_e.cyc, 2);
      end
    end
  // Reference model: picture contents plus clear progress.
  logic [CW-1:0] gold [DEPTH];
  bit m_clr = 0, m_done = 0, last_ack = 0;
  int m_next = 0;
  logic [CW-1:0] m_col = '0;
  int busy_cnt = 0, done_cnt = 0, clr_wr_cnt = 0;
  task automatic step();
    logic e_ack, e_we;
    int e_addr;
    logic [CW-1:0] e_wd;
    exp_t e_new;
    @(negedge clock);
    e_ack = 0; e_we = 0; e_addr = 0; e_wd = '0;
    if (disp_req) begin
      e_new.rgb = '0;
      if (disp_addr < DEPTH) begin
        e_addr = int'(disp_addr);
        e_new.rgb = gold[disp_addr];
      end
      e_new.cyc = cyc;
      sbq.push_back(e_new);
    end else if (m_clr) begin
      e_we = 1; e_addr = m_next; e_wd = m_col;
    end else if (wr_req) begin
      e_ack = 1;
      if (wr_addr < DEPTH) begin
        e_we = 1; e_addr = int'(wr_addr); e_wd = wr_rgb;
      end
    end
    chk("clr_busy", clr_busy, m_clr);
    chk("clr_done", clr_done, m_done);
    chk("wr_ack", wr_ack, e_ack);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    if (clr_busy) busy_cnt++;
    if (clr_done) done_cnt++;
    if (clr_busy && mem_we) clr_wr_cnt++;
    if (e_we) gold[e_addr] = e_wd;
    m_done = m_clr && !disp_req && m_next == DEPTH - 1;
    if (m_clr && !disp_req) begin
      if (m_next == DEPTH - 1) m_clr = 0;
      else m_next++;
    end else if (!m_clr && clr_start) begin
      m_clr = 1; m_next = 0; m_col = clr_rgb;
    end
    last_ack = e_ack;
    @(posedge clock);
    #1;
  endtask
  task automatic zero_counts();
    busy_cnt = 0; done_cnt = 0; clr_wr_cnt = 0;
  endtask
  task automatic check_image(input string name);
    int mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== gold[i]) mism++;
    chk(name, mism, 0);
  endtask
  task automatic run_clear(input string name);
    int n = 0;
    while ((m_clr || m_done) && n < 70000) begin
      step();
      n++;
    end
    if (n >= 70000) chk({name, "_timeout"}, 1, 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) gold[i] = 3'(i);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_rgb", disp_rgb, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    disp_req = 1; disp_addr = 16'd5;
    step();
    disp_req = 0;
    repeat (2) step();
    wr_req = 1; wr_addr = 16'd100; wr_rgb = 3'b110;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1; disp_addr = 16'(i + 1);
      step();
    end
    disp_req = 0;
    step();
    wr_req = 0;
    disp_req = 1; disp_addr = 16'd100;
    step();
    disp_addr = 16'(DEPTH);
    step();
    disp_req = 0; wr_req = 1; wr_addr = 16'(DEPTH); wr_rgb = 3'b111;
    step();
    wr_req = 0;
    repeat (2) step();
    for (int i = 0; i < 2000; i++) begin
      disp_req = $urandom % 2 == 1;
      disp_addr = ($urandom % 8 == 0) ? 16'(DEPTH + $urandom % 3) : 16'($urandom % DEPTH);
      if (!wr_req || last_ack) begin
        wr_req = $urandom % 3 != 0;
        wr_addr = ($urandom % 10 == 0) ? 16'(DEPTH) : 16'($urandom % DEPTH);
        wr_rgb = 3'($urandom);
      end
      step();
    end
    disp_req = 0; wr_req = 0;
    repeat (3) step();
    check_image("img_random");
    zero_counts();
    clr_rgb = 3'b011; clr_start = 1;
    step();
    clr_start = 0;
    run_clear("clear1");
    chk("clear1_busy_cycles", busy_cnt, DEPTH);
    chk("clear1_done_pulses", done_cnt, 1);
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 3'b011) n++;
    chk("clear1_fill", n, 0);
    zero_counts();
    clr_rgb = 3'b101; clr_start = 1;
    step();
    clr_start = 0; wr_req = 1; wr_addr = 16'd7; wr_rgb = 3'b010;
    n = 0;
    while (m_clr && n < 70000) begin
      disp_req = $urandom % 4 == 0;
      disp_addr = 16'($urandom % DEPTH);
      clr_start = n == 1000;
      clr_rgb = n == 1000 ? 3'b001 : 3'b101;
      step();
      n++;
    end
    if (n >= 70000) chk("clear2_timeout", 1, 0);
    disp_req = 0; clr_start = 0;
    step();
    chk("clear2_first_idle_ack", last_ack, 1);
    wr_req = 0;
    step();
    chk("clear2_granted_writes", clr_wr_cnt, DEPTH);
    chk("clear2_done_pulses", done_cnt, 1);
    check_image("img_clear2");
    clr_rgb = 3'b110; clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 500; i++) begin
      disp_req = i >= 495 || $urandom % 3 == 0;
      disp_addr = 16'($urandom % DEPTH);
      step();
    end
    reset = 0;
    #1;
    chk("arst_clr_busy", clr_busy, 0);
    chk("arst_clr_done", clr_done, 0);
    chk("arst_disp_valid", disp_valid, 0);
    chk("arst_disp_rgb", disp_rgb, 0);
    sbq.delete();
    m_clr = 0; m_done = 0;
    disp_req = 0;
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    step();
    check_image("img_partial");
    zero_counts();
    clr_rgb = 3'b100; clr_start = 1;
    step();
    clr_start = 0;
    run_clear("clear3");
    chk("clear3_busy_cycles", busy_cnt, DEPTH);
    chk("clear3_granted_writes", clr_wr_cnt, DEPTH);
    check_image("img_clear3");
    repeat (3) step();
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
